// File: rtl/dtu_pkg.sv
// DTU shared definitions: divisor table, message ROM, FSM state types, frame size.
// DTU_PARITY_EN adds an even parity bit to every frame.
package dtu_pkg;

   localparam int         CHAR_W      = 7;
   localparam int         CNT_W       = 5;
   localparam logic [1:0] DIV_SEL_RST = 2'd1;

`ifdef DTU_PARITY_EN
   localparam int FRAME_BITS = 10;
`else
   localparam int FRAME_BITS = 9;
`endif

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   // RX_WAIT is the gap between the two frames of one message.
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT
   } rx_state_e;

   function automatic logic [CNT_W:0] bit_period(input logic [1:0] sel);
      logic [CNT_W:0] n;
      case (sel)
         2'd0:    n = 6'd4;
         2'd1:    n = 6'd8;
         2'd2:    n = 6'd16;
         default: n = 6'd32;
      endcase
      return n;
   endfunction

   function automatic logic [CHAR_W-1:0] msg_char(input logic [1:0] sel, input logic idx);
      logic [CHAR_W-1:0] c;
      case ({sel, idx})
         3'b000:  c = 7'h4F;
         3'b001:  c = 7'h4B;
         3'b010:  c = 7'h48;
         3'b011:  c = 7'h49;
         3'b100:  c = 7'h41;
         3'b101:  c = 7'h42;
         default: c = 7'h5A;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dtu_baud_gen.sv
// Bit-period timing for the DTU: TX bit tick plus RX half-period and full-period ticks.
module dtu_baud_gen
   import dtu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] div_sel,
   input  logic       tx_run,
   input  logic       rx_run,
   input  logic       rx_restart,
   output logic       tx_tick,
   output logic       rx_half_tick,
   output logic       rx_full_tick
);

   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [CNT_W-1:0] last_cnt;
   logic [CNT_W-1:0] half_cnt;

   // Counters sit at zero while their side is idle, so a bit always starts a full period.
   always_comb begin
      last_cnt     = CNT_W'(bit_period(div_sel) - 6'd1);
      half_cnt     = CNT_W'((bit_period(div_sel) >> 1) - 6'd1);
      tx_tick      = tx_run && (tx_cnt_q == last_cnt);
      rx_half_tick = rx_run && (rx_cnt_q == half_cnt);
      rx_full_tick = rx_run && (rx_cnt_q == last_cnt);
      tx_cnt_d     = (!tx_run || tx_tick) ? '0 : tx_cnt_q + CNT_W'(1);
      rx_cnt_d     = (!rx_run || rx_restart || rx_full_tick) ? '0 : rx_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
      end else begin
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

endmodule

// File: rtl/dtu.sv
// DTU top: sends a fixed two-character message on an internal serial line looped back to a receiver.
// Define DTU_PARITY_EN to add and check an even parity bit in every frame.
module dtu
   import dtu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clk_div_ld,
   input  logic [1:0]        clk_div_sel,
   input  logic              tx_start,
   input  logic [1:0]        tx_character_sel,
   input  logic              rx_ack,
   output logic [CHAR_W-1:0] rx_character1,
   output logic [CHAR_W-1:0] rx_character2,
   output logic              tx_busy,
   output logic              rx_busy,
   output logic              rx_ready,
   output logic              rx_error,
   output tx_state_e         dbg_tx_state,
   output rx_state_e         dbg_rx_state
);

   logic [1:0]        div_sel_q, div_sel_d;
   logic              start_hist_q, start_hist_d;
   tx_state_e         tx_state_q, tx_state_d;
   logic [1:0]        tx_sel_q, tx_sel_d;
   logic              tx_frame_q, tx_frame_d;
   logic [2:0]        tx_bit_q, tx_bit_d;
   rx_state_e         rx_state_q, rx_state_d;
   logic              rx_frame_q, rx_frame_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [CHAR_W-1:0] rx_shift_q, rx_shift_d;
   logic [CHAR_W-1:0] rx_first_q, rx_first_d;
   logic              rx_err_acc_q, rx_err_acc_d;
   logic [CHAR_W-1:0] rx_char1_q, rx_char1_d;
   logic [CHAR_W-1:0] rx_char2_q, rx_char2_d;
   logic              rx_ready_q, rx_ready_d;
   logic              rx_error_q, rx_error_d;

   logic              tx_accept;
   logic [CHAR_W-1:0] tx_char;
   logic              tx_line;
   logic              rx_line;
   logic              tx_tick, rx_half_tick, rx_full_tick;
   logic              rx_run, rx_restart;

   assign tx_busy       = (tx_state_q != TX_IDLE);
   assign rx_busy       = (rx_state_q != RX_IDLE);
   assign rx_ready      = rx_ready_q;
   assign rx_error      = rx_error_q;
   assign rx_character1 = rx_char1_q;
   assign rx_character2 = rx_char2_q;
   assign dbg_tx_state  = tx_state_q;
   assign dbg_rx_state  = rx_state_q;
   assign rx_line       = tx_line;
   assign rx_run        = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT);

   dtu_baud_gen u_baud (
      .clk          (clk),
      .rst          (rst),
      .div_sel      (div_sel_q),
      .tx_run       (tx_busy),
      .rx_run       (rx_run),
      .rx_restart   (rx_restart),
      .tx_tick      (tx_tick),
      .rx_half_tick (rx_half_tick),
      .rx_full_tick (rx_full_tick)
   );

   always_comb begin
      tx_char = msg_char(tx_sel_q, tx_frame_q);
      tx_line = 1'b1;
      case (tx_state_q)
         TX_START:  tx_line = 1'b0;
         TX_DATA:   tx_line = tx_char[tx_bit_q];
         TX_PARITY: tx_line = ^tx_char;
         default:   tx_line = 1'b1;
      endcase
   end

   always_comb begin
      div_sel_d    = (clk_div_ld && !tx_busy && !rx_busy) ? clk_div_sel : div_sel_q;
      start_hist_d = tx_start;
      tx_accept    = tx_start && !start_hist_q && en && (tx_state_q == TX_IDLE);
      tx_state_d   = tx_state_q;
      tx_sel_d     = tx_sel_q;
      tx_frame_d   = tx_frame_q;
      tx_bit_d     = tx_bit_q;
      if (!en) begin
         tx_state_d = TX_IDLE;
      end else begin
         case (tx_state_q)
            TX_IDLE: if (tx_accept) begin
               tx_state_d = TX_START;
               tx_sel_d   = tx_character_sel;
               tx_frame_d = 1'b0;
               tx_bit_d   = 3'd0;
            end
            TX_START: if (tx_tick) begin
               tx_state_d = TX_DATA;
               tx_bit_d   = 3'd0;
            end
            TX_DATA: if (tx_tick) begin
               if (tx_bit_q == 3'd6) begin
                  tx_bit_d = 3'd0;
`ifdef DTU_PARITY_EN
                  tx_state_d = TX_PARITY;
`else
                  tx_state_d = TX_STOP;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end
            TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
            TX_STOP: if (tx_tick) begin
               if (tx_frame_q) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_state_d = TX_START;
                  tx_frame_d = 1'b1;
               end
            end
            default: tx_state_d = TX_IDLE;
         endcase
      end
   end

   // rx_ready behaves as a sticky valid: it rises with a completed message and drops
   // only on rx_ack; a completion in the same cycle as rx_ack wins.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_frame_d   = rx_frame_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_first_d   = rx_first_q;
      rx_err_acc_d = rx_err_acc_q;
      rx_char1_d   = rx_char1_q;
      rx_char2_d   = rx_char2_q;
      rx_ready_d   = rx_ready_q;
      rx_error_d   = rx_error_q;
      rx_restart   = 1'b0;
      if (rx_ack) begin
         rx_ready_d = 1'b0;
         rx_error_d = 1'b0;
      end
      if (!en) begin
         rx_state_d = RX_IDLE;
      end else begin
         case (rx_state_q)
            RX_IDLE: if (!rx_line) begin
               rx_state_d   = RX_START;
               rx_frame_d   = 1'b0;
               rx_err_acc_d = 1'b0;
            end
            RX_WAIT: if (!rx_line) rx_state_d = RX_START;
            RX_START: if (rx_half_tick) begin
               if (rx_line) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_restart = 1'b1;
                  rx_bit_d   = 3'd0;
               end
            end
            RX_DATA: if (rx_full_tick) begin
               rx_shift_d = {rx_line, rx_shift_q[CHAR_W-1:1]};
               if (rx_bit_q == 3'd6) begin
                  rx_bit_d = 3'd0;
`ifdef DTU_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
            RX_PARITY: if (rx_full_tick) begin
               rx_err_acc_d = rx_err_acc_q | (rx_line != ^rx_shift_q);
               rx_state_d   = RX_STOP;
            end
            RX_STOP: if (rx_full_tick) begin
               if (!rx_frame_q) begin
                  rx_first_d   = rx_shift_q;
                  rx_frame_d   = 1'b1;
                  rx_err_acc_d = rx_err_acc_q | !rx_line;
                  rx_state_d   = RX_WAIT;
               end else begin
                  rx_state_d = RX_IDLE;
                  rx_char1_d = rx_first_q;
                  rx_char2_d = rx_shift_q;
                  rx_ready_d = 1'b1;
                  rx_error_d = rx_error_d | rx_err_acc_q | !rx_line;
               end
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_sel_q    <= DIV_SEL_RST;
         start_hist_q <= 1'b1;
         tx_state_q   <= TX_IDLE;
         tx_sel_q     <= 2'd0;
         tx_frame_q   <= 1'b0;
         tx_bit_q     <= 3'd0;
         rx_state_q   <= RX_IDLE;
         rx_frame_q   <= 1'b0;
         rx_bit_q     <= 3'd0;
         rx_shift_q   <= '0;
         rx_first_q   <= '0;
         rx_err_acc_q <= 1'b0;
         rx_char1_q   <= '0;
         rx_char2_q   <= '0;
         rx_ready_q   <= 1'b0;
         rx_error_q   <= 1'b0;
      end else begin
         div_sel_q    <= div_sel_d;
         start_hist_q <= start_hist_d;
         tx_state_q   <= tx_state_d;
         tx_sel_q     <= tx_sel_d;
         tx_frame_q   <= tx_frame_d;
         tx_bit_q     <= tx_bit_d;
         rx_state_q   <= rx_state_d;
         rx_frame_q   <= rx_frame_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_first_q   <= rx_first_d;
         rx_err_acc_q <= rx_err_acc_d;
         rx_char1_q   <= rx_char1_d;
         rx_char2_q   <= rx_char2_d;
         rx_ready_q   <= rx_ready_d;
         rx_error_q   <= rx_error_d;
      end
   end

endmodule

// File: tb/tb_dtu.sv
// Self-checking bench for dtu: directed messages with a completion scoreboard.
// Frame length follows DTU_PARITY_EN in the same way as the design build.
module tb_dtu;
   import dtu_pkg::*;

`ifdef DTU_PARITY_EN
   localparam int MSG_BITS = 20;
`else
   localparam int MSG_BITS = 18;
`endif

   logic       clk;
   logic       rst;
   logic       en;
   logic       clk_div_ld;
   logic [1:0] clk_div_sel;
   logic       tx_start;
   logic [1:0] tx_character_sel;
   logic       rx_ack;
   logic [6:0] rx_character1;
   logic [6:0] rx_character2;
   logic       tx_busy;
   logic       rx_busy;
   logic       rx_ready;
   logic       rx_error;
   tx_state_e  dbg_tx_state;
   rx_state_e  dbg_rx_state;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Expected completion: {rx_ready, rx_error, rx_character1, rx_character2}
   logic [15:0] exp_q[$];

   dtu u_dut (
      .clk              (clk),
      .rst              (rst),
      .en               (en),
      .clk_div_ld       (clk_div_ld),
      .clk_div_sel      (clk_div_sel),
      .tx_start         (tx_start),
      .tx_character_sel (tx_character_sel),
      .rx_ack           (rx_ack),
      .rx_character1    (rx_character1),
      .rx_character2    (rx_character2),
      .tx_busy          (tx_busy),
      .rx_busy          (rx_busy),
      .rx_ready         (rx_ready),
      .rx_error         (rx_error),
      .dbg_tx_state     (dbg_tx_state),
      .dbg_rx_state     (dbg_rx_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic load_div(input logic [1:0] sel);
      @(posedge clk); #1;
      clk_div_sel = sel;
      clk_div_ld  = 1'b1;
      @(posedge clk); #1;
      clk_div_ld  = 1'b0;
   endtask

   task automatic pulse_ack();
      @(posedge clk); #1;
      rx_ack = 1'b1;
      @(posedge clk); #1;
      rx_ack = 1'b0;
   endtask

   task automatic start_only(input logic [1:0] sel);
      @(posedge clk); #1;
      tx_character_sel = sel;
      tx_start         = 1'b1;
      @(posedge clk); #1;
      tx_start         = 1'b0;
   endtask

   // Issues a message and measures how many cycles tx_busy stays high.
   task automatic send(input logic [1:0] sel, input int exp_len, input string name,
                       input int poke_at, input logic poke_start, input logic poke_ld);
      int len;
      start_only(sel);
      len = 0;
      @(negedge clk);
      while (tx_busy && len < 2000) begin
         len++;
         if (len == poke_at) begin
            tx_start    = poke_start;
            clk_div_sel = 2'd0;
            clk_div_ld  = poke_ld;
         end
         if (len == poke_at + 1) begin
            tx_start   = 1'b0;
            clk_div_ld = 1'b0;
         end
         @(negedge clk);
      end
      check(name, len, exp_len);
   endtask

   initial begin : monitor
      logic        prev_busy;
      logic [15:0] exp;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_busy && !rx_busy) begin
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL rx_unexpected: got 0x%0h, expected no completion",
                        {rx_ready, rx_error, rx_character1, rx_character2});
            end else begin
               exp = exp_q.pop_front();
               check("rx_msg", {rx_ready, rx_error, rx_character1, rx_character2}, exp);
            end
         end
         prev_busy = rx_busy;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin : stimulus
      int seen;
      rst              = 1'b1;
      en               = 1'b1;
      clk_div_ld       = 1'b0;
      clk_div_sel      = 2'd0;
      tx_start         = 1'b1;
      tx_character_sel = 2'd0;
      rx_ack           = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {tx_busy, rx_busy, rx_ready, rx_error, rx_character1, rx_character2}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("no_start_after_reset", {tx_busy, rx_busy, rx_ready}, 0);
      @(posedge clk); #1;
      tx_start = 1'b0;

      // HI at N=8
      exp_q.push_back({1'b1, 1'b0, 7'h48, 7'h49});
      send(2'd1, MSG_BITS * 8, "len_hi_n8", 0, 1'b0, 1'b0);

      // OK at N=4, overwriting an unacknowledged message
      load_div(2'd0);
      exp_q.push_back({1'b1, 1'b0, 7'h4F, 7'h4B});
      send(2'd0, MSG_BITS * 4, "len_ok_n4", 0, 1'b0, 1'b0);
      @(negedge clk);
      check("ready_before_ack", {rx_ready, rx_error}, 2'b10);
      pulse_ack();
      @(negedge clk);
      check("ack_clears", {rx_ready, rx_error, rx_character1, rx_character2}, {2'b00, 7'h4F, 7'h4B});

      // divisor load during tx_busy is ignored
      load_div(2'd1);
      exp_q.push_back({1'b1, 1'b0, 7'h41, 7'h42});
      send(2'd2, MSG_BITS * 8, "len_ld_while_busy", 40, 1'b0, 1'b1);
      pulse_ack();

      // second tx_start edge while busy is dropped
      exp_q.push_back({1'b1, 1'b0, 7'h5A, 7'h5A});
      send(2'd3, MSG_BITS * 8, "len_restart_ignored", 50, 1'b1, 1'b0);
      seen = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_busy) seen++;
      end
      check("no_queued_tx", seen, 0);
      pulse_ack();

      // second frame stop bit forced low on the loopback line
      exp_q.push_back({1'b1, 1'b1, 7'h48, 7'h49});
      fork
         send(2'd1, MSG_BITS * 8, "len_forced_stop", 0, 1'b0, 1'b0);
         begin
            repeat ((MSG_BITS - 1) * 8 + 4) @(posedge clk);
            #1 force u_dut.rx_line = 1'b0;
            repeat (3) @(posedge clk);
            #1 release u_dut.rx_line;
         end
      join
      @(negedge clk);
      check("stop_error_flags", {rx_ready, rx_error}, 2'b11);
      pulse_ack();
      @(negedge clk);
      check("ack_clears_error", {rx_ready, rx_error}, 2'b00);

      // en dropped mid-frame
      start_only(2'd2);
      repeat (50) @(posedge clk);
      exp_q.push_back({1'b0, 1'b0, 7'h48, 7'h49});
      #1 en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("en_abort_flags", {tx_busy, rx_busy, rx_ready, rx_error}, 0);
      repeat (20) @(negedge clk);
      check("en_abort_idle", {tx_busy, rx_busy, rx_ready}, 0);
      @(posedge clk); #1;
      en = 1'b1;

      // reset mid-message at N=4 discards it and restores N=8
      load_div(2'd0);
      start_only(2'd0);
      repeat (40) @(posedge clk);
      exp_q.push_back(16'h0000);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_reset_outputs", {tx_busy, rx_busy, rx_ready, rx_error, rx_character1, rx_character2}, 0);
      @(posedge clk); #1;
      exp_q.push_back({1'b1, 1'b0, 7'h4F, 7'h4B});
      send(2'd0, MSG_BITS * 8, "len_after_reset_n8", 0, 1'b0, 1'b0);

      repeat (20) @(negedge clk);
      check("all_completions_seen", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
